// File: rtl/rf_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter_pkg
//
// Purpose:
//   Shared constants and types for the register-file writeback arbiter and
//   its load scoreboard.
//
// Contents:
//   RW          register width
//   REGNO       number of registers
//   REGNO_LOG   register select width
//   CNT_W       starvation counter width
//   src_e       encoding of which writeback source owns the rf write port
//   sel_onehot  decode of a register select into a one-hot enable vector
// ---------------------------------------------------------------------------
package rf_wb_arbiter_pkg;

    localparam int RW        = 16;
    localparam int REGNO     = 8;
    localparam int REGNO_LOG = 3;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MEM  = 2'd1,
        SRC_EXE  = 2'd2,
        SRC_DBG  = 2'd3
    } src_e;

    function automatic logic [REGNO-1:0] sel_onehot(input logic [REGNO_LOG-1:0] sel);
        logic [REGNO-1:0] oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_scoreboard.sv
// ---------------------------------------------------------------------------
// rf_scoreboard
//
// Purpose:
//   Tracks which registers have a load in flight, answers the issue stage's
//   hazard lookup and flags scoreboard protocol errors.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   set_en/sel    a load was issued to register set_sel
//   clr_en/sel    a load completed (mem writeback) to register clr_sel
//   wr_en/sel     a non-load source (exe/dbg) is writing register wr_sel
//   chk_a/b/d     issue-stage source A, source B and destination
//   pending       registered scoreboard bits
//   stall         any checked register has a load in flight
//   err           single-cycle protocol error pulse
// ---------------------------------------------------------------------------
module rf_scoreboard
    import rf_wb_arbiter_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 set_en,
    input  logic [REGNO_LOG-1:0] set_sel,
    input  logic                 clr_en,
    input  logic [REGNO_LOG-1:0] clr_sel,
    input  logic                 wr_en,
    input  logic [REGNO_LOG-1:0] wr_sel,
    input  logic [REGNO_LOG-1:0] chk_a,
    input  logic [REGNO_LOG-1:0] chk_b,
    input  logic [REGNO_LOG-1:0] chk_d,
    output logic [REGNO-1:0]     pending,
    output logic                 stall,
    output logic                 err
);

    logic [REGNO-1:0] pending_q;
    logic [REGNO-1:0] set_mask;
    logic [REGNO-1:0] clr_mask;
    logic             same_reg;
    logic             err_clr;
    logic             err_set;
    logic             err_wr;

    // Decode the set and clear requests into masks so both can act on the
    // vector in the same cycle.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask = sel_onehot(set_sel);
        if (clr_en) clr_mask = sel_onehot(clr_sel);
    end

    // Clear is applied before set, so a register that is both completed and
    // re-issued in one cycle stays pending.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
        end
    end

    assign pending = pending_q;

    // Hazard lookup uses the registered bits only; a completion in this
    // cycle is not bypassed, the stall drops one cycle later.
    assign stall = pending_q[chk_a] | pending_q[chk_b] | pending_q[chk_d];

    // A re-issue to a register whose load completes in the same cycle is a
    // legal back-to-back load, not a double issue.
    assign same_reg = set_en && clr_en && (set_sel == clr_sel);

    assign err_clr = clr_en && !pending_q[clr_sel];
    assign err_set = set_en && pending_q[set_sel] && !same_reg;
    assign err_wr  = wr_en && pending_q[wr_sel];
    assign err     = err_clr | err_set | err_wr;

endmodule

// File: rtl/rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rf_wb_arbiter
//
// Purpose:
//   Owns the single register-file write port and arbitrates it between
//   memory-load completion (mem), execute writeback (exe) and debug poke
//   (dbg). Also hosts the load scoreboard used by the issue stage.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_mem_valid/sel/d             load data returning (always accepted)
//   i_exe_valid/sel/d, o_exe_ready  exe writeback handshake
//   i_dbg_valid/sel/d, o_dbg_ready  debug write handshake
//   i_ld_issue, i_ld_sel          load issued to memory this cycle
//   i_chk_a/b/d, o_stall          issue-stage hazard lookup
//   o_pending                     scoreboard bits
//   o_rf_d, o_rf_ie, o_rf_gie     rf write port (combinational from grant)
//   o_err                         sticky protocol error
//
// Parameters:
//   STARVE_LIM  cycles dbg may wait before it outranks exe (1..15)
// ---------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_mem_valid,
    input  logic [REGNO_LOG-1:0] i_mem_sel,
    input  logic [RW-1:0]        i_mem_d,
    input  logic                 i_exe_valid,
    input  logic [REGNO_LOG-1:0] i_exe_sel,
    input  logic [RW-1:0]        i_exe_d,
    output logic                 o_exe_ready,
    input  logic                 i_dbg_valid,
    input  logic [REGNO_LOG-1:0] i_dbg_sel,
    input  logic [RW-1:0]        i_dbg_d,
    output logic                 o_dbg_ready,
    input  logic                 i_ld_issue,
    input  logic [REGNO_LOG-1:0] i_ld_sel,
    input  logic [REGNO_LOG-1:0] i_chk_a,
    input  logic [REGNO_LOG-1:0] i_chk_b,
    input  logic [REGNO_LOG-1:0] i_chk_d,
    output logic                 o_stall,
    output logic [REGNO-1:0]     o_pending,
    output logic [RW-1:0]        o_rf_d,
    output logic [REGNO-1:0]     o_rf_ie,
    output logic                 o_rf_gie,
    output logic                 o_err
);

    localparam logic [CNT_W-1:0] LIM     = CNT_W'(STARVE_LIM);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    src_e                 grant;
    logic [CNT_W-1:0]     starve_cnt;
    logic                 starved;
    logic [REGNO_LOG-1:0] grant_sel;
    logic [RW-1:0]        grant_d;
    logic                 mem_wb;
    logic                 other_wb;
    logic                 sb_err;
    logic                 err_q;

    assign starved = (starve_cnt >= LIM);

    // Grant selection: mem always wins, a starved dbg outranks exe, and
    // nothing is granted while reset is held so the rf sees no write.
    always_comb begin
        grant = SRC_NONE;
        if (i_rst) begin
            grant = SRC_NONE;
        end else if (i_mem_valid) begin
            grant = SRC_MEM;
        end else if (i_dbg_valid && starved) begin
            grant = SRC_DBG;
        end else if (i_exe_valid) begin
            grant = SRC_EXE;
        end else if (i_dbg_valid) begin
            grant = SRC_DBG;
        end
    end

    // Route the granted source's register select and data onto the port;
    // idle drives zeros.
    always_comb begin
        grant_sel = '0;
        grant_d   = '0;
        case (grant)
            SRC_MEM: begin
                grant_sel = i_mem_sel;
                grant_d   = i_mem_d;
            end
            SRC_EXE: begin
                grant_sel = i_exe_sel;
                grant_d   = i_exe_d;
            end
            SRC_DBG: begin
                grant_sel = i_dbg_sel;
                grant_d   = i_dbg_d;
            end
            default: begin
                grant_sel = '0;
                grant_d   = '0;
            end
        endcase
    end

    assign o_rf_gie    = (grant != SRC_NONE);
    assign o_rf_ie     = o_rf_gie ? sel_onehot(grant_sel) : '0;
    assign o_rf_d      = grant_d;
    assign o_exe_ready = (grant == SRC_EXE);
    assign o_dbg_ready = (grant == SRC_DBG);

    // Counts how long dbg has been waiting; saturates so a long mem burst
    // cannot wrap it back below the limit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (!i_dbg_valid || (grant == SRC_DBG)) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign mem_wb   = (grant == SRC_MEM);
    assign other_wb = (grant == SRC_EXE) || (grant == SRC_DBG);

    rf_scoreboard u_scoreboard (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .set_en  (i_ld_issue),
        .set_sel (i_ld_sel),
        .clr_en  (mem_wb),
        .clr_sel (i_mem_sel),
        .wr_en   (other_wb),
        .wr_sel  (grant_sel),
        .chk_a   (i_chk_a),
        .chk_b   (i_chk_b),
        .chk_d   (i_chk_d),
        .pending (o_pending),
        .stall   (o_stall),
        .err     (sb_err)
    );

    // Sticky error flag, only cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else if (sb_err) begin
            err_q <= 1'b1;
        end
    end

    assign o_err = err_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_wb_arbiter
//
// Purpose:
//   Self-checking bench for rf_wb_arbiter: a table of single-cycle
//   arbitration vectors followed by hand-written multi-cycle sequences for
//   starvation, scoreboard, error and reset behaviour.
// ---------------------------------------------------------------------------
module tb_rf_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic [2:0]  mem_sel;
    logic [15:0] mem_d;
    logic        exe_valid;
    logic [2:0]  exe_sel;
    logic [15:0] exe_d;
    logic        exe_ready;
    logic        dbg_valid;
    logic [2:0]  dbg_sel;
    logic [15:0] dbg_d;
    logic        dbg_ready;
    logic        ld_issue;
    logic [2:0]  ld_sel;
    logic [2:0]  chk_a;
    logic [2:0]  chk_b;
    logic [2:0]  chk_d;
    logic        stall;
    logic [7:0]  pending;
    logic [15:0] rf_d;
    logic [7:0]  rf_ie;
    logic        rf_gie;
    logic        err;

    int checks = 0;
    int errors = 0;

    rf_wb_arbiter #(.STARVE_LIM(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_mem_valid (mem_valid),
        .i_mem_sel   (mem_sel),
        .i_mem_d     (mem_d),
        .i_exe_valid (exe_valid),
        .i_exe_sel   (exe_sel),
        .i_exe_d     (exe_d),
        .o_exe_ready (exe_ready),
        .i_dbg_valid (dbg_valid),
        .i_dbg_sel   (dbg_sel),
        .i_dbg_d     (dbg_d),
        .o_dbg_ready (dbg_ready),
        .i_ld_issue  (ld_issue),
        .i_ld_sel    (ld_sel),
        .i_chk_a     (chk_a),
        .i_chk_b     (chk_b),
        .i_chk_d     (chk_d),
        .o_stall     (stall),
        .o_pending   (pending),
        .o_rf_d      (rf_d),
        .o_rf_ie     (rf_ie),
        .o_rf_gie    (rf_gie),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mem_v;
        logic [2:0]  mem_s;
        logic [15:0] mem_dat;
        logic        exe_v;
        logic [2:0]  exe_s;
        logic [15:0] exe_dat;
        logic        dbg_v;
        logic [2:0]  dbg_s;
        logic [15:0] dbg_dat;
        logic        exp_gie;
        logic [7:0]  exp_ie;
        logic [15:0] exp_d;
        logic        exp_exe_rdy;
        logic        exp_dbg_rdy;
    } vec_t;

    vec_t vecs[8];

    // Compare one observed value against the bench's expectation.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Drive every input to its idle value.
    task automatic idle();
        rst       = 1'b0;
        mem_valid = 1'b0; mem_sel = '0; mem_d = '0;
        exe_valid = 1'b0; exe_sel = '0; exe_d = '0;
        dbg_valid = 1'b0; dbg_sel = '0; dbg_d = '0;
        ld_issue  = 1'b0; ld_sel  = '0;
        chk_a = '0; chk_b = '0; chk_d = '0;
    endtask

    // Start a new cycle: move to the falling edge and clear all inputs.
    task automatic step();
        @(negedge clk);
        idle();
    endtask

    // Apply one table vector on a fresh cycle and let it settle.
    task automatic applyStimulus(input vec_t v);
        step();
        mem_valid = v.mem_v; mem_sel = v.mem_s; mem_d = v.mem_dat;
        exe_valid = v.exe_v; exe_sel = v.exe_s; exe_d = v.exe_dat;
        dbg_valid = v.dbg_v; dbg_sel = v.dbg_s; dbg_d = v.dbg_dat;
        #1;
    endtask

    task automatic checkPort(input string tag, input logic gie, input logic [7:0] ie,
                             input logic [15:0] d, input logic er, input logic dr);
        checkOutput({tag, ".gie"}, 32'(rf_gie), 32'(gie));
        checkOutput({tag, ".ie"}, 32'(rf_ie), 32'(ie));
        checkOutput({tag, ".d"}, 32'(rf_d), 32'(d));
        checkOutput({tag, ".exe_ready"}, 32'(exe_ready), 32'(er));
        checkOutput({tag, ".dbg_ready"}, 32'(dbg_ready), 32'(dr));
    endtask

    task automatic doReset();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        //              mem               exe                 dbg                 gie ie     d        er   dr
        vecs[0] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,8'h00,16'h0000,1'b0,1'b0};
        vecs[1] = '{1'b0,3'd0,16'h0000, 1'b1,3'd5,16'hBEEF, 1'b0,3'd0,16'h0000, 1'b1,8'h20,16'hBEEF,1'b1,1'b0};
        vecs[2] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd7,16'h00AA, 1'b1,8'h80,16'h00AA,1'b0,1'b1};
        vecs[3] = '{1'b0,3'd0,16'h0000, 1'b1,3'd1,16'h1111, 1'b1,3'd2,16'h2222, 1'b1,8'h02,16'h1111,1'b1,1'b0};
        vecs[4] = '{1'b1,3'd0,16'h0F0F, 1'b1,3'd3,16'h3333, 1'b1,3'd4,16'h4444, 1'b1,8'h01,16'h0F0F,1'b0,1'b0};
        vecs[5] = '{1'b1,3'd7,16'hFFFF, 1'b0,3'd0,16'h0000, 1'b1,3'd6,16'h6666, 1'b1,8'h80,16'hFFFF,1'b0,1'b0};
        vecs[6] = '{1'b0,3'd0,16'h0000, 1'b1,3'd0,16'h0001, 1'b0,3'd0,16'h0000, 1'b1,8'h01,16'h0001,1'b1,1'b0};
        vecs[7] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd3,16'h0000, 1'b1,8'h08,16'h0000,1'b0,1'b1};

        idle();
        rst = 1'b1;

        // Reset holds the port idle even with every source requesting.
        @(negedge clk);
        mem_valid = 1'b1; mem_sel = 3'd2; mem_d = 16'hAAAA;
        exe_valid = 1'b1; exe_sel = 3'd3; exe_d = 16'hBBBB;
        dbg_valid = 1'b1; dbg_sel = 3'd4; dbg_d = 16'hCCCC;
        #1;
        checkPort("reset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        checkOutput("reset.pending", 32'(pending), 32'h0);
        checkOutput("reset.err", 32'(err), 32'h0);

        // Single-cycle arbitration table; an idle cycle between vectors
        // keeps the starvation counter at zero.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkPort($sformatf("vec%0d", i), vecs[i].exp_gie, vecs[i].exp_ie,
                      vecs[i].exp_d, vecs[i].exp_exe_rdy, vecs[i].exp_dbg_rdy);
            step();
        end
        doReset();

        // Priority: mem to pending r3 beats exe to r5, then exe goes through.
        step(); ld_issue = 1'b1; ld_sel = 3'd3;
        step();
        mem_valid = 1'b1; mem_sel = 3'd3; mem_d = 16'h1234;
        exe_valid = 1'b1; exe_sel = 3'd5; exe_d = 16'hBEEF;
        #1;
        checkOutput("prio.pending", 32'(pending), 32'h08);
        checkPort("prio.mem", 1'b1, 8'h08, 16'h1234, 1'b0, 1'b0);
        step();
        exe_valid = 1'b1; exe_sel = 3'd5; exe_d = 16'hBEEF;
        #1;
        checkPort("prio.exe", 1'b1, 8'h20, 16'hBEEF, 1'b1, 1'b0);
        step(); #1;
        checkOutput("prio.err", 32'(err), 32'h0);
        checkOutput("prio.pending_clr", 32'(pending), 32'h00);

        // Starvation: dbg wins on cycles 5 and 10 of continuous contention.
        for (int k = 1; k <= 10; k++) begin
            step();
            exe_valid = 1'b1; exe_sel = 3'd1; exe_d = 16'h0001;
            dbg_valid = 1'b1; dbg_sel = 3'd2; dbg_d = 16'h0002;
            #1;
            if (k == 5 || k == 10)
                checkPort($sformatf("starve%0d", k), 1'b1, 8'h04, 16'h0002, 1'b0, 1'b1);
            else
                checkPort($sformatf("starve%0d", k), 1'b1, 8'h02, 16'h0001, 1'b1, 1'b0);
        end

        // Scoreboard set, lookup on each check port, and delayed clear.
        step(); ld_issue = 1'b1; ld_sel = 3'd2;
        step(); chk_a = 3'd2; #1;
        checkOutput("sb.pending", 32'(pending), 32'h04);
        checkOutput("sb.stall_a", 32'(stall), 32'h1);
        chk_a = 3'd0; chk_b = 3'd2; #1;
        checkOutput("sb.stall_b", 32'(stall), 32'h1);
        chk_b = 3'd0; chk_d = 3'd2; #1;
        checkOutput("sb.stall_d", 32'(stall), 32'h1);
        chk_d = 3'd1; #1;
        checkOutput("sb.nostall", 32'(stall), 32'h0);
        step();
        chk_a = 3'd2; mem_valid = 1'b1; mem_sel = 3'd2; mem_d = 16'h2222; #1;
        checkOutput("sb.stall_nobypass", 32'(stall), 32'h1);
        step(); chk_a = 3'd2; #1;
        checkOutput("sb.stall_cleared", 32'(stall), 32'h0);

        // Same-register set and clear in one cycle, then different registers.
        step(); ld_issue = 1'b1; ld_sel = 3'd6;
        step();
        ld_issue = 1'b1; ld_sel = 3'd6;
        mem_valid = 1'b1; mem_sel = 3'd6; mem_d = 16'h6666;
        step();
        ld_issue = 1'b1; ld_sel = 3'd1;
        #1;
        checkOutput("same.pending", 32'(pending), 32'h40);
        checkOutput("same.err", 32'(err), 32'h0);
        mem_valid = 1'b1; mem_sel = 3'd6; mem_d = 16'h6060;
        step(); #1;
        checkOutput("diff.pending", 32'(pending), 32'h02);
        step(); mem_valid = 1'b1; mem_sel = 3'd1; mem_d = 16'h0101;
        step(); #1;
        checkOutput("diff.cleared", 32'(pending), 32'h00);
        checkOutput("diff.err", 32'(err), 32'h0);

        // exe write to a pending register: write still happens, error flagged.
        step(); ld_issue = 1'b1; ld_sel = 3'd4;
        step(); exe_valid = 1'b1; exe_sel = 3'd4; exe_d = 16'h4E4E; #1;
        checkPort("exe_pend", 1'b1, 8'h10, 16'h4E4E, 1'b1, 1'b0);
        step(); #1;
        checkOutput("exe_pend.err", 32'(err), 32'h1);
        doReset();

        // mem writeback to non-pending r1: rf written, sticky error.
        step(); #1;
        checkOutput("memerr.err_before", 32'(err), 32'h0);
        mem_valid = 1'b1; mem_sel = 3'd1; mem_d = 16'h5A5A; #1;
        checkPort("memerr", 1'b1, 8'h02, 16'h5A5A, 1'b0, 1'b0);
        step(); #1;
        checkOutput("memerr.err", 32'(err), 32'h1);
        for (int k = 0; k < 3; k++) step();
        #1;
        checkOutput("memerr.sticky", 32'(err), 32'h1);
        doReset();

        // Double load issue to the same register.
        step(); ld_issue = 1'b1; ld_sel = 3'd5;
        step(); ld_issue = 1'b1; ld_sel = 3'd5; #1;
        checkOutput("dblissue.err_before", 32'(err), 32'h0);
        step(); #1;
        checkOutput("dblissue.err", 32'(err), 32'h1);
        doReset();

        // Reset mid-load discards r4; a late return writes rf and flags.
        step(); ld_issue = 1'b1; ld_sel = 3'd4;
        step(); #1;
        checkOutput("rstload.pending", 32'(pending), 32'h10);
        rst = 1'b1;
        exe_valid = 1'b1; exe_sel = 3'd3; exe_d = 16'h3333;
        #1;
        checkPort("rstload.inreset", 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0);
        step(); #1;
        checkOutput("rstload.pending_after", 32'(pending), 32'h00);
        checkOutput("rstload.err_after", 32'(err), 32'h0);
        mem_valid = 1'b1; mem_sel = 3'd4; mem_d = 16'h4444; #1;
        checkPort("rstload.late", 1'b1, 8'h10, 16'h4444, 1'b0, 1'b0);
        step(); #1;
        checkOutput("rstload.late_err", 32'(err), 32'h1);
        doReset();

        // Counter saturation: 17 blocked cycles must not wrap below the limit.
        for (int k = 0; k < 17; k++) begin
            step();
            mem_valid = 1'b1; mem_sel = 3'd0; mem_d = 16'h0000;
            dbg_valid = 1'b1; dbg_sel = 3'd2; dbg_d = 16'hD00D;
            #1;
            if (k == 0 || k == 16)
                checkOutput($sformatf("sat.blocked%0d", k), 32'(dbg_ready), 32'h0);
        end
        step();
        exe_valid = 1'b1; exe_sel = 3'd1; exe_d = 16'h0E0E;
        dbg_valid = 1'b1; dbg_sel = 3'd2; dbg_d = 16'hD00D;
        #1;
        checkPort("sat.dbg_wins", 1'b1, 8'h04, 16'hD00D, 1'b0, 1'b1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
